seq_scheduler: RTL and testbench

SEQ_SCHEDULER -- requirements
Module: seq_scheduler

---
 rtl/seq_scheduler.sv | 145 ++++++++++++++
 tb/tb_seq_scheduler.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_scheduler.sv
// rtl/seq_scheduler.sv - two-requester round-robin pattern serializer (option: SEQ_SCHED_LSB_FIRST_EN)
module seq_scheduler #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  clrn,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] din1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  ds,
    output logic                  dval,
    output logic                  owner,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                state_q;
    logic [DATA_WIDTH-1:0] sr_q;
    logic [DATA_WIDTH-1:0] pat_q;
    logic [DATA_WIDTH-1:0] dout_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  ptr_q;
    logic                  gnt0_q;
    logic                  gnt1_q;
    logic                  ds_q;
    logic                  dval_q;
    logic                  owner_q;
    logic                  busy_q;
    logic                  done_q;

    logic                  sel_d;
    logic [DATA_WIDTH-1:0] din_d;
    logic [DATA_WIDTH-1:0] sr_d;

    function automatic logic head_bit(input logic [DATA_WIDTH-1:0] v);
`ifdef SEQ_SCHED_LSB_FIRST_EN
        return v[0];
`else
        return v[DATA_WIDTH-1];
`endif
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_once(input logic [DATA_WIDTH-1:0] v);
`ifdef SEQ_SCHED_LSB_FIRST_EN
        return v >> 1;
`else
        return v << 1;
`endif
    endfunction

    // On a tie the requester that was not served last wins; a lone request always wins.
    always_comb begin
        sel_d = req1;
        if (req0 && req1) begin
            sel_d = ~ptr_q;
        end
        din_d = sel_d ? din1 : din0;
        sr_d  = shift_once(sr_q);
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= IDLE;
            sr_q    <= '0;
            pat_q   <= '0;
            dout_q  <= '0;
            cnt_q   <= '0;
            ptr_q   <= 1'b1;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            ds_q    <= 1'b0;
            dval_q  <= 1'b0;
            owner_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            gnt0_q <= 1'b0;
            gnt1_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req0 || req1) begin
                        state_q <= SHIFT;
                        sr_q    <= din_d;
                        pat_q   <= din_d;
                        cnt_q   <= CNT_LAST;
                        ptr_q   <= sel_d;
                        owner_q <= sel_d;
                        gnt0_q  <= ~sel_d;
                        gnt1_q  <= sel_d;
                        ds_q    <= head_bit(din_d);
                        dval_q  <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                SHIFT: begin
                    sr_q <= sr_d;
                    if (cnt_q == '0) begin
                        state_q <= DONE;
                        ds_q    <= 1'b0;
                        dval_q  <= 1'b0;
                        done_q  <= 1'b1;
                        dout_q  <= pat_q;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                        ds_q  <= head_bit(sr_d);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    ds_q    <= 1'b0;
                    dval_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt0  = gnt0_q;
    assign gnt1  = gnt1_q;
    assign ds    = ds_q;
    assign dval  = dval_q;
    assign owner = owner_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign dout  = dout_q;

endmodule

// File: tb/tb_seq_scheduler.sv
// tb/tb_seq_scheduler.sv - directed self-checking bench for seq_scheduler
module tb_seq_scheduler;

    localparam int DW = 8;

    logic          clk;
    logic          clrn;
    logic          req0;
    logic          req1;
    logic [DW-1:0] din0;
    logic [DW-1:0] din1;
    logic          gnt0;
    logic          gnt1;
    logic          ds;
    logic          dval;
    logic          owner;
    logic          busy;
    logic          done;
    logic [DW-1:0] dout;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int gnt0_cnt = 0;
    int gnt1_cnt = 0;
    int done_cnt = 0;

    seq_scheduler #(.DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .clrn  (clrn),
        .req0  (req0),
        .req1  (req1),
        .din0  (din0),
        .din1  (din1),
        .gnt0  (gnt0),
        .gnt1  (gnt1),
        .ds    (ds),
        .dval  (dval),
        .owner (owner),
        .busy  (busy),
        .done  (done),
        .dout  (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (gnt0 === 1'b1) gnt0_cnt++;
        if (gnt1 === 1'b1) gnt1_cnt++;
        if (done === 1'b1) done_cnt++;
    end

    // Arrival order of ds packed first-bit-first into a byte.
    function automatic logic [DW-1:0] ser_of(input logic [DW-1:0] v);
        logic [DW-1:0] r;
`ifdef SEQ_SCHED_LSB_FIRST_EN
        for (int i = 0; i < DW; i++) r[i] = v[DW-1-i];
`else
        r = v;
`endif
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(output int n);
        n = 0;
        while (gnt0 !== 1'b1 && gnt1 !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic serialize(output logic [DW-1:0] bits, output int n);
        bits = '0;
        n = 0;
        while (dval === 1'b1 && n < 20) begin
            bits = {bits[DW-2:0], ds};
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        clrn = 1'b1; req0 = 1'b0; req1 = 1'b0; din0 = '0; din1 = '0;
        #1 clrn = 1'b0;
        #1;
        tests_run++;
        if ({gnt0, gnt1, ds, dval, owner, busy, done, dout} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b/%h required all zero",
                     {gnt0, gnt1, ds, dval, owner, busy, done}, dout);
        end
        #2 clrn = 1'b1;
    endtask

    task automatic test_basic();
        int n;
        int w;
        logic [DW-1:0] bits;
        req0 = 1'b1; din0 = 8'b0000_1110;
        wait_gnt(w);
        tests_run++;
        if (w !== 1 || gnt0 !== 1'b1 || gnt1 !== 1'b0 || owner !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_grant: wait=%0d gnt0=%b gnt1=%b owner=%b busy=%b required 1 1 0 0 1",
                     w, gnt0, gnt1, owner, busy);
        end
        req0 = 1'b0;
        serialize(bits, n);
        tests_run++;
        if (n !== DW || bits !== ser_of(8'h0E)) begin
            tests_failed++;
            $display("FAIL basic_serial: n=%0d bits=%b required n=8 bits=%b", n, bits, ser_of(8'h0E));
        end
        tests_run++;
        if (done !== 1'b1 || dval !== 1'b0 || ds !== 1'b0 || dout !== 8'h0E || owner !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_done: done=%b dval=%b ds=%b dout=%h owner=%b required 1 0 0 0e 0",
                     done, dval, ds, dout, owner);
        end
        tick();
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0 || dout !== 8'h0E) begin
            tests_failed++;
            $display("FAIL basic_idle: done=%b busy=%b dout=%h required 0 0 0e", done, busy, dout);
        end
    endtask

    task automatic test_tie();
        int n;
        int w;
        int c0;
        logic [DW-1:0] bits;
        clrn = 1'b0;
        #1 clrn = 1'b1;
        req0 = 1'b1; req1 = 1'b1; din0 = 8'hA5; din1 = 8'h3C;
        wait_gnt(w);
        c0 = cyc;
        tests_run++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL tie_first: gnt0=%b gnt1=%b required 1 0", gnt0, gnt1);
        end
        req0 = 1'b0;
        serialize(bits, n);
        tests_run++;
        if (n !== DW || bits !== ser_of(8'hA5)) begin
            tests_failed++;
            $display("FAIL tie_serial0: n=%0d bits=%h required 8 %h", n, bits, ser_of(8'hA5));
        end
        wait_gnt(w);
        tests_run++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || owner !== 1'b1 || (cyc - c0) !== DW + 2) begin
            tests_failed++;
            $display("FAIL tie_second: gnt1=%b gnt0=%b owner=%b spacing=%0d required 1 0 1 10",
                     gnt1, gnt0, owner, cyc - c0);
        end
        req1 = 1'b0;
        serialize(bits, n);
        tests_run++;
        if (n !== DW || bits !== ser_of(8'h3C) || done !== 1'b1 || dout !== 8'h3C) begin
            tests_failed++;
            $display("FAIL tie_serial1: n=%0d bits=%h done=%b dout=%h required 8 %h 1 3c",
                     n, bits, done, dout, ser_of(8'h3C));
        end
        tick();
    endtask

    task automatic test_round_robin();
        int n;
        int w;
        int g0;
        logic [DW-1:0] bits;
        req1 = 1'b1; din1 = 8'h5A;
        wait_gnt(w);
        g0 = gnt0_cnt;
        tests_run++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
            tests_failed++;
            $display("FAIL rr_first: gnt1=%b gnt0=%b required 1 0", gnt1, gnt0);
        end
        tick(); tick();
        req0 = 1'b1; din0 = 8'hC3;
        serialize(bits, n);
        tests_run++;
        if (gnt0_cnt !== g0 || done !== 1'b1 || dout !== 8'h5A) begin
            tests_failed++;
            $display("FAIL rr_ignored: gnt0 pulses=%0d done=%b dout=%h required %0d 1 5a",
                     gnt0_cnt, done, dout, g0);
        end
        wait_gnt(w);
        tests_run++;
        if (w !== 2 || gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL rr_second: wait=%0d gnt0=%b gnt1=%b required 2 1 0", w, gnt0, gnt1);
        end
        req0 = 1'b0;
        serialize(bits, n);
        tests_run++;
        if (n !== DW || bits !== ser_of(8'hC3)) begin
            tests_failed++;
            $display("FAIL rr_serial: n=%0d bits=%h required 8 %h", n, bits, ser_of(8'hC3));
        end
        wait_gnt(w);
        tests_run++;
        if (gnt1 !== 1'b1 || owner !== 1'b1) begin
            tests_failed++;
            $display("FAIL rr_third: gnt1=%b owner=%b required 1 1", gnt1, owner);
        end
        req1 = 1'b0;
        tick();
        req0 = 1'b1;
        tick();
        req0 = 1'b0;
        g0 = gnt0_cnt;
        serialize(bits, n);
        tick(); tick(); tick();
        tests_run++;
        if (gnt0_cnt !== g0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL rr_dropped: gnt0 pulses=%0d busy=%b required %0d 0", gnt0_cnt, busy, g0);
        end
    endtask

    task automatic test_abort();
        int n;
        int w;
        int d0;
        logic [DW-1:0] bits;
        req0 = 1'b1; din0 = 8'hFF;
        wait_gnt(w);
        req0 = 1'b0;
        tick(); tick(); tick();
        d0 = done_cnt;
        tests_run++;
        if (dval !== 1'b1 || dout === 8'h00) begin
            tests_failed++;
            $display("FAIL abort_pre: dval=%b dout=%h required 1 nonzero", dval, dout);
        end
        clrn = 1'b0;
        #1;
        tests_run++;
        if ({gnt0, gnt1, ds, dval, owner, busy, done, dout} !== '0) begin
            tests_failed++;
            $display("FAIL abort_outputs: got %b/%h required all zero",
                     {gnt0, gnt1, ds, dval, owner, busy, done}, dout);
        end
        tick(); tick();
        clrn = 1'b1;
        tick();
        tests_run++;
        if (done_cnt !== d0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_no_done: done pulses=%0d busy=%b required %0d 0", done_cnt, busy, d0);
        end
        req0 = 1'b1; req1 = 1'b1; din0 = 8'h81; din1 = 8'h7E;
        wait_gnt(w);
        tests_run++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_tie: gnt0=%b gnt1=%b required 1 0", gnt0, gnt1);
        end
        req0 = 1'b0; req1 = 1'b0;
        serialize(bits, n);
        tests_run++;
        if (n !== DW || bits !== ser_of(8'h81) || dout !== 8'h81) begin
            tests_failed++;
            $display("FAIL abort_serial: n=%0d bits=%h dout=%h required 8 %h 81",
                     n, bits, dout, ser_of(8'h81));
        end
        tick();
    endtask

    task automatic test_din_change();
        int n;
        int w;
        logic [DW-1:0] bits;
        req0 = 1'b1; din0 = 8'hF0;
        wait_gnt(w);
        req0 = 1'b0;
        din0 = 8'h0F;
        serialize(bits, n);
        tests_run++;
        if (n !== DW || bits !== ser_of(8'hF0) || dout !== 8'hF0 || owner !== 1'b0) begin
            tests_failed++;
            $display("FAIL din_change: n=%0d bits=%h dout=%h owner=%b required 8 %h f0 0",
                     n, bits, dout, owner, ser_of(8'hF0));
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_round_robin();
        test_abort();
        test_din_change();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish, required finish before 50000 ns");
        $fatal(1);
    end

endmodule
